// File: rtl/contra_sprite_pkg.sv
// Shared types and constants for the Contra-style enemy sprite datapath.
// Palette index 0 is the chroma-key green and is never drawn.
package contra_sprite_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DYING = 2'd2,
        DEAD  = 2'd3
    } anim_state_t;

    localparam logic [2:0] TRANSPARENT_IDX = 3'd0;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

endpackage

// File: rtl/sprite_anim_fsm.sv
// Per-frame animation state machine for the running enemy.
// Covers idle, the run cycle, the dying blink and dead, plus the frame index and death pulse.
module sprite_anim_fsm
    import contra_sprite_pkg::*;
#(
    parameter int NUM_FRAMES  = 3,
    parameter int FRAME_HOLD  = 6,
    parameter int DYING_TICKS = 36
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       spawn,
    input  logic       kill,
    input  logic       moving,
    output logic [1:0] frame_idx,
    output logic [1:0] anim_state,
    output logic       visible,
    output logic       death_done
);

    anim_state_t state_q, state_d;
    logic [2:0]  hold_q, hold_d;
    logic [5:0]  dying_q, dying_d;
    logic [1:0]  frame_q, frame_d;
    logic        death_done_q, death_done_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= DEAD;
            hold_q       <= '0;
            dying_q      <= '0;
            frame_q      <= '0;
            death_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            dying_q      <= dying_d;
            frame_q      <= frame_d;
            death_done_q <= death_done_d;
        end
    end

    // kill is tested before frame_tick everywhere, so it wins any same-cycle tie.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        dying_d      = dying_q;
        frame_d      = frame_q;
        death_done_d = 1'b0;
        case (state_q)
            DEAD: begin
                if (spawn) begin
                    state_d = IDLE;
                    hold_d  = '0;
                    dying_d = '0;
                    frame_d = '0;
                end
            end
            IDLE: begin
                frame_d = '0;
                if (kill) begin
                    state_d = DYING;
                    dying_d = '0;
                end else if (frame_tick && moving) begin
                    state_d = RUN;
                    hold_d  = '0;
                end
            end
            RUN: begin
                if (kill) begin
                    state_d = DYING;
                    dying_d = '0;
                end else if (frame_tick) begin
                    if (!moving) begin
                        state_d = IDLE;
                        frame_d = '0;
                        hold_d  = '0;
                    end else if (hold_q == 3'(FRAME_HOLD - 1)) begin
                        hold_d  = '0;
                        frame_d = (frame_q == 2'(NUM_FRAMES - 1)) ? 2'd0 : frame_q + 2'd1;
                    end else begin
                        hold_d = hold_q + 3'd1;
                    end
                end
            end
            DYING: begin
                if (frame_tick) begin
                    if (dying_q == 6'(DYING_TICKS - 1)) begin
                        state_d      = DEAD;
                        death_done_d = 1'b1;
                    end else begin
                        dying_d = dying_q + 6'd1;
                    end
                end
            end
            default: state_d = DEAD;
        endcase
    end

    // Bit 2 of the dying counter gives a blink that toggles every 4 frames.
    always_comb begin
        visible = 1'b0;
        case (state_q)
            IDLE, RUN: visible = 1'b1;
            DYING:     visible = dying_q[2];
            default:   visible = 1'b0;
        endcase
    end

    assign frame_idx  = frame_q;
    assign anim_state = state_q;
    assign death_done = death_done_q;

endmodule

// File: rtl/enemy_sprite_sequencer.sv
// Running-enemy sprite sequencer: hit test and mirrored ROM addressing per pixel,
// a 3-stage pipeline through the synchronous sprite ROM, and the animation FSM.
module enemy_sprite_sequencer
    import contra_sprite_pkg::*;
#(
    parameter int SPRITE_W    = 24,
    parameter int SPRITE_H    = 34,
    parameter int NUM_FRAMES  = 3,
    parameter int FRAME_HOLD  = 6,
    parameter int DYING_TICKS = 36,
    parameter int ADDR_W      = 12
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_tick,
    input  logic              spawn,
    input  logic              kill,
    input  logic              moving,
    input  logic              facing_left,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [2:0]        rom_data,
    output logic [2:0]        pal_index,
    output logic              pix_valid,
    output logic [1:0]        frame_idx,
    output logic [1:0]        anim_state,
    output logic              death_done
);

    localparam int FRAME_PIX = SPRITE_W * SPRITE_H;

    logic visible;

    sprite_anim_fsm #(
        .NUM_FRAMES (NUM_FRAMES),
        .FRAME_HOLD (FRAME_HOLD),
        .DYING_TICKS(DYING_TICKS)
    ) u_fsm (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_tick(frame_tick),
        .spawn     (spawn),
        .kill      (kill),
        .moving    (moving),
        .frame_idx (frame_idx),
        .anim_state(anim_state),
        .visible   (visible),
        .death_done(death_done)
    );

    logic signed [10:0] dx, dy;
    logic [9:0]         col;
    logic               hit;

    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              hit1_q, hit1_d, vis1_q, vis1_d;
    logic              hit2_q, hit2_d, vis2_q, vis2_d;
    logic [2:0]        pal_q, pal_d;
    logic              valid_q, valid_d;

    // The 11-bit signed difference keeps pixels left of or above the box negative,
    // so the hit test never wraps around the screen edge.
    always_comb begin
        dx  = $signed({1'b0, draw_x}) - $signed({1'b0, pos_x});
        dy  = $signed({1'b0, draw_y}) - $signed({1'b0, pos_y});
        hit = !dx[10] && !dy[10] && (dx[9:0] < 10'(SPRITE_W)) && (dy[9:0] < 10'(SPRITE_H));
        col = facing_left ? (10'(SPRITE_W - 1) - dx[9:0]) : dx[9:0];

        rom_addr_d = '0;
        if (hit) begin
            rom_addr_d = ADDR_W'(frame_idx) * ADDR_W'(FRAME_PIX)
                       + ADDR_W'(dy[9:0]) * ADDR_W'(SPRITE_W)
                       + ADDR_W'(col);
        end
        hit1_d  = hit;
        vis1_d  = visible;
        hit2_d  = hit1_q;
        vis2_d  = vis1_q;
        pal_d   = rom_data;
        valid_d = hit2_q && (rom_data != TRANSPARENT_IDX) && vis2_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom_addr_q <= '0;
            hit1_q     <= 1'b0;
            vis1_q     <= 1'b0;
            hit2_q     <= 1'b0;
            vis2_q     <= 1'b0;
            pal_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            hit1_q     <= hit1_d;
            vis1_q     <= vis1_d;
            hit2_q     <= hit2_d;
            vis2_q     <= vis2_d;
            pal_q      <= pal_d;
            valid_q    <= valid_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign pal_index = pal_q;
    assign pix_valid = valid_q;

endmodule
